// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: adds two WIDTH-bit operands over NIB clock cycles. A single
// shared 4-bit carry look-ahead slice is used, one nibble per cycle, LSB nibble
// first. Operands arrive on a valid/ready handshake and the result (sum, carry-out,
// signed overflow) leaves on a second valid/ready handshake.

// carry_lahead: combinational 4-bit carry look-ahead slice.
// CARRY_AHEAD[i] is the carry out of bit i. CARRY_AHEAD[3] is the slice carry-out.
module carry_lahead (
    output logic [3:0] SUM,
    output logic [3:0] CARRY_AHEAD,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_IN
);
    logic [3:0] prop;
    logic [3:0] gen;
    logic [3:0] carry_into;

    assign prop = A ^ B;
    assign gen  = A & B;

    // Every carry is flattened to two levels so that no carry ripples through the slice.
    assign CARRY_AHEAD[0] = gen[0] | (prop[0] & C_IN);
    assign CARRY_AHEAD[1] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & C_IN);
    assign CARRY_AHEAD[2] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                          | (prop[2] & prop[1] & prop[0] & C_IN);
    assign CARRY_AHEAD[3] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                          | (prop[3] & prop[2] & prop[1] & gen[0])
                          | (prop[3] & prop[2] & prop[1] & prop[0] & C_IN);

    assign carry_into = {CARRY_AHEAD[2:0], C_IN};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sum_bit
        assign SUM[gi] = prop[gi] ^ carry_into[gi];
    end
endmodule

module cla_word_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry_reg;
    logic             c_out_reg;
    logic             ovf_reg;
    logic [IDX_W-1:0] idx_reg;

    logic [3:0]       a_slice;
    logic [3:0]       b_slice;
    logic [3:0]       slice_sum;
    logic [3:0]       slice_carry;
    logic [1:0]       unused_low_carry;

    // Select the operand nibbles addressed by idx for the shared slice.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                a_slice = a_reg[i*4 +: 4];
                b_slice = b_reg[i*4 +: 4];
            end
        end
    end

    carry_lahead u_slice (
        .SUM         (slice_sum),
        .CARRY_AHEAD (slice_carry),
        .A           (a_slice),
        .B           (b_slice),
        .C_IN        (carry_reg)
    );

    // The low carries only matter inside the slice. The word-level result needs bits 3 and 2.
    assign unused_low_carry = slice_carry[1:0];

    // In RUN, the nibble that idx selects is replaced with the slice sum. The other nibbles keep their value.
    for (genvar gi = 0; gi < NIB; gi++) begin : g_sum_nib
        assign sum_next[gi*4 +: 4] = (state_reg == RUN && idx_reg == IDX_W'(gi))
                                   ? slice_sum : sum_reg[gi*4 +: 4];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, run for NIB cycles, then hold in DONE until the result is taken.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)            state_next = RUN;
            RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:    if (out_ready)           state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then step one nibble per cycle through the slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
        end else if (state_reg == IDLE) begin
            if (in_valid) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= c_in;
                idx_reg   <= '0;
            end
        end else if (state_reg == RUN) begin
            sum_reg   <= sum_next;
            carry_reg <= slice_carry[3];
            if (idx_reg == LAST_IDX) begin
                c_out_reg <= slice_carry[3];
                ovf_reg   <= slice_carry[3] ^ slice_carry[2];
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign sum       = sum_reg;
    assign c_out     = c_out_reg;
    assign ovf       = ovf_reg;
endmodule
